// File: rtl/vj_scan_pkg.sv
// vj_scan_pkg: shared types, default pyramid geometry and level-search helper for the scan sequencer.
package vj_scan_pkg;
  localparam int MAX_LEVELS = 16;
  localparam logic [4:0] NO_LEVEL = 5'd16;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SCAN, S_DONE} scan_state_t;
  typedef logic [15:0] coord_t;
  // 320x240 source shrunk by 1.25 per level; index 0 is the full-resolution image.
  localparam logic [8:0][15:0] PYR_WIDTHS = {
    16'd53, 16'd66, 16'd83, 16'd104, 16'd131, 16'd163, 16'd204, 16'd256, 16'd320
  };
  localparam logic [8:0][15:0] PYR_HEIGHTS = {
    16'd39, 16'd49, 16'd62, 16'd78, 16'd97, 16'd122, 16'd153, 16'd192, 16'd240
  };
  function automatic logic [4:0] next_valid_level(logic [MAX_LEVELS-1:0] mask, int cur);
    next_valid_level = NO_LEVEL;
    for (int i = MAX_LEVELS - 1; i >= 0; i--)
      if (mask[i] && i > cur) next_valid_level = 5'(i);
  endfunction
endpackage

// File: rtl/vj_level_walker.sv
// vj_level_walker: row/col stepper for one pyramid level; load restarts at (0,0) with new limits.
module vj_level_walker
  import vj_scan_pkg::*;
#(
  parameter int STRIDE = 1
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   load,
  input  logic   step,
  input  coord_t col_max,
  input  coord_t row_max,
  output coord_t row,
  output coord_t col,
  output logic   at_end,
  output logic   at_end_nxt
);
  coord_t row_q, row_d, col_q, col_d, cmax_q, cmax_d, rmax_q, rmax_d;
  logic end_q, wrap;
  function automatic logic past(coord_t v, coord_t lim);
    return ({1'b0, v} + 17'(STRIDE)) > {1'b0, lim};
  endfunction
  always_comb begin
    wrap = past(col_q, cmax_q);
    cmax_d = load ? col_max : cmax_q;
    rmax_d = load ? row_max : rmax_q;
    col_d = load ? '0 : step ? (wrap ? '0 : col_q + coord_t'(STRIDE)) : col_q;
    row_d = load ? '0 : (step && wrap) ? row_q + coord_t'(STRIDE) : row_q;
    at_end_nxt = past(col_d, cmax_d) && past(row_d, rmax_d);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
      cmax_q <= '0;
      rmax_q <= '0;
      end_q <= 1'b0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      cmax_q <= cmax_d;
      rmax_q <= rmax_d;
      end_q <= at_end_nxt;
    end
  assign row = row_q;
  assign col = col_q;
  assign at_end = end_q;
endmodule

// File: rtl/vj_scan_sequencer.sv
// vj_scan_sequencer: settle wait, then level/row/col window walk with backpressure and abort.
// Defining VJ_SCAN_PERF_EN adds saturating perf_windows / perf_stall counters.
module vj_scan_sequencer
  import vj_scan_pkg::*;
#(
  parameter int LEVELS = 9,
  parameter logic [LEVELS-1:0][15:0] LEVEL_WIDTHS = PYR_WIDTHS,
  parameter logic [LEVELS-1:0][15:0] LEVEL_HEIGHTS = PYR_HEIGHTS,
  parameter int WINDOW_SIZE = 24,
  parameter int STRIDE = 1,
  parameter int SETTLE_CYCLES = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        win_valid,
  input  logic        win_ready,
  output logic [3:0]  win_level,
  output logic [15:0] win_row,
  output logic [15:0] win_col,
  output logic        win_last,
  output logic        busy,
`ifdef VJ_SCAN_PERF_EN
  output logic        done,
  output logic [31:0] perf_windows,
  output logic [31:0] perf_stall
`else
  output logic        done
`endif
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [16:0] SPAN = 17'(WINDOW_SIZE + 1);
  scan_state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0] level_q, level_d;
  logic valid_q, last_q, busy_q, done_q;
  logic [MAX_LEVELS-1:0] mask;
  coord_t cmax_tab [MAX_LEVELS];
  coord_t rmax_tab [MAX_LEVELS];
  logic [4:0] first_lvl, nxt_lvl, load_lvl;
  logic hs, settled, load, step, at_end, at_end_nxt, final_d;
  // Level validity and per-level position limits are fixed at elaboration.
  for (genvar i = 0; i < MAX_LEVELS; i++) begin : g_lvl
    if (i < LEVELS) begin : g_on
      assign mask[i] = {1'b0, LEVEL_WIDTHS[i]} >= SPAN && {1'b0, LEVEL_HEIGHTS[i]} >= SPAN;
      assign cmax_tab[i] = LEVEL_WIDTHS[i] - 16'(WINDOW_SIZE + 1);
      assign rmax_tab[i] = LEVEL_HEIGHTS[i] - 16'(WINDOW_SIZE + 1);
    end else begin : g_off
      assign mask[i] = 1'b0;
      assign cmax_tab[i] = '0;
      assign rmax_tab[i] = '0;
    end
  end
  always_comb begin
    first_lvl = next_valid_level(mask, -1);
    nxt_lvl = next_valid_level(mask, int'(level_q));
    hs = valid_q && win_ready;
    settled = state_q == S_SETTLE && cnt_q == CW'(SETTLE_CYCLES);
    load_lvl = settled ? first_lvl : nxt_lvl;
    load = !abort && ((settled && first_lvl != NO_LEVEL) || (hs && at_end && !last_q));
    step = !abort && hs && !at_end;
    level_d = load ? load_lvl[3:0] : level_q;
    final_d = next_valid_level(mask, int'(level_d)) == NO_LEVEL;
  end
  vj_level_walker #(.STRIDE(STRIDE)) u_walker (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .col_max   (cmax_tab[load_lvl[3:0]]),
    .row_max   (rmax_tab[load_lvl[3:0]]),
    .row       (win_row),
    .col       (win_col),
    .at_end    (at_end),
    .at_end_nxt(at_end_nxt)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (abort) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      level_q <= level_d;
      if (load || step) last_q <= at_end_nxt && final_d;
      case (state_q)
        S_IDLE:
          if (start) begin
            state_q <= S_SETTLE;
            cnt_q <= CW'(1);
            busy_q <= 1'b1;
          end
        S_SETTLE:
          if (!settled) cnt_q <= cnt_q + 1'b1;
          else if (first_lvl == NO_LEVEL) begin
            state_q <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state_q <= S_SCAN;
            valid_q <= 1'b1;
          end
        S_SCAN:
          if (hs && last_q) begin
            state_q <= S_DONE;
            valid_q <= 1'b0;
            last_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  assign win_valid = valid_q;
  assign win_level = level_q;
  assign win_last = last_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef VJ_SCAN_PERF_EN
  logic [31:0] pw_q, ps_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      pw_q <= '0;
      ps_q <= '0;
    end else if (state_q == S_IDLE && start && !abort) begin
      pw_q <= '0;
      ps_q <= '0;
    end else begin
      if (hs && !abort && ~&pw_q) pw_q <= pw_q + 1'b1;
      if (valid_q && !win_ready && ~&ps_q) ps_q <= ps_q + 1'b1;
    end
  assign perf_windows = pw_q;
  assign perf_stall = ps_q;
`endif
endmodule

// File: tb/tb_vj_scan_sequencer.sv
// tb_vj_scan_sequencer: five parameter sets checked against a nested-loop window list model.
module tb_vj_scan_sequencer;
  import vj_scan_pkg::*;
  localparam int WS = 24;
  localparam logic [1:0][15:0] W1 = {16'd30, 16'd27};
  localparam logic [1:0][15:0] H1 = {16'd25, 16'd26};
  localparam logic [2:0][15:0] W2 = {16'd26, 16'd30, 16'd20};
  localparam logic [2:0][15:0] H2 = {16'd25, 16'd25, 16'd25};
  localparam logic [1:0][15:0] W3 = {16'd30, 16'd10};
  localparam logic [1:0][15:0] H3 = {16'd10, 16'd30};
  localparam logic [3:0][15:0] W4 = {16'd29, 16'd33, 16'd24, 16'd40};
  localparam logic [3:0][15:0] H4 = {16'd40, 16'd27, 16'd50, 16'd31};
  typedef struct {int l; int r; int c;} win_t;
  logic clk = 1'b0, reset, start, abort, ready;
  logic v [5], lst [5], bsy [5], dn [5];
  logic [3:0] lv [5];
  logic [15:0] rw [5], cl [5];
  logic [31:0] pw [5], ps [5];
  int sel, n_cmp, n_bad;
  int nlev [5] = '{9, 2, 3, 2, 4};
  int st [5] = '{1, 2, 1, 1, 3};
  int sc [5] = '{10, 3, 5, 4, 1};
  int cw [5][16], ch [5][16];
  win_t exp_q [$];
  always #5 clk = ~clk;
`ifdef VJ_SCAN_PERF_EN
  vj_scan_sequencer u0 (.clock(clk), .reset(reset), .start(start), .abort(abort), .win_valid(v[0]),
    .win_ready(ready), .win_level(lv[0]), .win_row(rw[0]), .win_col(cl[0]), .win_last(lst[0]),
    .busy(bsy[0]), .done(dn[0]), .perf_windows(pw[0]), .perf_stall(ps[0]));
  vj_scan_sequencer #(.LEVELS(2), .LEVEL_WIDTHS(W1), .LEVEL_HEIGHTS(H1), .STRIDE(2), .SETTLE_CYCLES(3)) u1 (
    .clock(clk), .reset(reset), .start(start), .abort(abort), .win_valid(v[1]), .win_ready(ready),
    .win_level(lv[1]), .win_row(rw[1]), .win_col(cl[1]), .win_last(lst[1]), .busy(bsy[1]), .done(dn[1]),
    .perf_windows(pw[1]), .perf_stall(ps[1]));
  vj_scan_sequencer #(.LEVELS(3), .LEVEL_WIDTHS(W2), .LEVEL_HEIGHTS(H2), .STRIDE(1), .SETTLE_CYCLES(5)) u2 (
    .clock(clk), .reset(reset), .start(start), .abort(abort), .win_valid(v[2]), .win_ready(ready),
    .win_level(lv[2]), .win_row(rw[2]), .win_col(cl[2]), .win_last(lst[2]), .busy(bsy[2]), .done(dn[2]),
    .perf_windows(pw[2]), .perf_stall(ps[2]));
  vj_scan_sequencer #(.LEVELS(2), .LEVEL_WIDTHS(W3), .LEVEL_HEIGHTS(H3), .STRIDE(1), .SETTLE_CYCLES(4)) u3 (
    .clock(clk), .reset(reset), .start(start), .abort(abort), .win_valid(v[3]), .win_ready(ready),
    .win_level(lv[3]), .win_row(rw[3]), .win_col(cl[3]), .win_last(lst[3]), .busy(bsy[3]), .done(dn[3]),
    .perf_windows(pw[3]), .perf_stall(ps[3]));
  vj_scan_sequencer #(.LEVELS(4), .LEVEL_WIDTHS(W4), .LEVEL_HEIGHTS(H4), .STRIDE(3), .SETTLE_CYCLES(1)) u4 (
    .clock(clk), .reset(reset), .start(start), .abort(abort), .win_valid(v[4]), .win_ready(ready),
    .win_level(lv[4]), .win_row(rw[4]), .win_col(cl[4]), .win_last(lst[4]), .busy(bsy[4]), .done(dn[4]),
    .perf_windows(pw[4]), .perf_stall(ps[4]));
`else
  vj_scan_sequencer u0 (.clock(clk), .reset(reset), .start(start), .abort(abort), .win_valid(v[0]),
    .win_ready(ready), .win_level(lv[0]), .win_row(rw[0]), .win_col(cl[0]), .win_last(lst[0]),
    .busy(bsy[0]), .done(dn[0]));
  vj_scan_sequencer #(.LEVELS(2), .LEVEL_WIDTHS(W1), .LEVEL_HEIGHTS(H1), .STRIDE(2), .SETTLE_CYCLES(3)) u1 (
    .clock(clk), .reset(reset), .start(start), .abort(abort), .win_valid(v[1]), .win_ready(ready),
    .win_level(lv[1]), .win_row(rw[1]), .win_col(cl[1]), .win_last(lst[1]), .busy(bsy[1]), .done(dn[1]));
  vj_scan_sequencer #(.LEVELS(3), .LEVEL_WIDTHS(W2), .LEVEL_HEIGHTS(H2), .STRIDE(1), .SETTLE_CYCLES(5)) u2 (
    .clock(clk), .reset(reset), .start(start), .abort(abort), .win_valid(v[2]), .win_ready(ready),
    .win_level(lv[2]), .win_row(rw[2]), .win_col(cl[2]), .win_last(lst[2]), .busy(bsy[2]), .done(dn[2]));
  vj_scan_sequencer #(.LEVELS(2), .LEVEL_WIDTHS(W3), .LEVEL_HEIGHTS(H3), .STRIDE(1), .SETTLE_CYCLES(4)) u3 (
    .clock(clk), .reset(reset), .start(start), .abort(abort), .win_valid(v[3]), .win_ready(ready),
    .win_level(lv[3]), .win_row(rw[3]), .win_col(cl[3]), .win_last(lst[3]), .busy(bsy[3]), .done(dn[3]));
  vj_scan_sequencer #(.LEVELS(4), .LEVEL_WIDTHS(W4), .LEVEL_HEIGHTS(H4), .STRIDE(3), .SETTLE_CYCLES(1)) u4 (
    .clock(clk), .reset(reset), .start(start), .abort(abort), .win_valid(v[4]), .win_ready(ready),
    .win_level(lv[4]), .win_row(rw[4]), .win_col(cl[4]), .win_last(lst[4]), .busy(bsy[4]), .done(dn[4]));
  for (genvar i = 0; i < 5; i++) begin : g_np
    assign pw[i] = '0;
    assign ps[i] = '0;
  end
`endif
  task automatic check(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s (inst %0d): got %0d, expected %0d at %0t", tag, sel, got, want, $time);
    end
  endtask
  task automatic init_geometry();
    for (int l = 0; l < 9; l++) begin
      cw[0][l] = int'(PYR_WIDTHS[4'(l)]);
      ch[0][l] = int'(PYR_HEIGHTS[4'(l)]);
    end
    cw[1][0] = int'(W1[0]); cw[1][1] = int'(W1[1]);
    ch[1][0] = int'(H1[0]); ch[1][1] = int'(H1[1]);
    cw[2][0] = int'(W2[0]); cw[2][1] = int'(W2[1]); cw[2][2] = int'(W2[2]);
    ch[2][0] = int'(H2[0]); ch[2][1] = int'(H2[1]); ch[2][2] = int'(H2[2]);
    cw[3][0] = int'(W3[0]); cw[3][1] = int'(W3[1]);
    ch[3][0] = int'(H3[0]); ch[3][1] = int'(H3[1]);
    cw[4][0] = int'(W4[0]); cw[4][1] = int'(W4[1]); cw[4][2] = int'(W4[2]); cw[4][3] = int'(W4[3]);
    ch[4][0] = int'(H4[0]); ch[4][1] = int'(H4[1]); ch[4][2] = int'(H4[2]); ch[4][3] = int'(H4[3]);
  endtask
  // Reference: every window position that fits, in level, row, column order.
  task automatic build(input int id, input int cap);
    exp_q.delete();
    for (int l = 0; l < nlev[id]; l++)
      if (cw[id][l] > WS && ch[id][l] > WS)
        for (int r = 0; r + WS < ch[id][l] && exp_q.size() < cap; r += st[id])
          for (int c = 0; c + WS < cw[id][l] && exp_q.size() < cap; c += st[id])
            exp_q.push_back('{l, r, c});
  endtask
  task automatic clear();
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check("abort_beats_start_busy", int'(bsy[sel]), 0);
  endtask
  task automatic run(input int id, input int cap, input bit full, input int pct, input int abort_at,
                     input bit hold);
    int k, idx, cyc, stalls, held;
    sel = id;
    build(id, cap);
    clear();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    check("busy_after_start", int'(bsy[id]), 1);
    while (!v[id] && !dn[id] && k < sc[id] + 5) begin
      start = ($urandom_range(3) == 0);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check("settle_latency", k, sc[id]);
    if (exp_q.size() == 0) begin
      check("empty_done", int'(dn[id]), 1);
      check("empty_valid", int'(v[id]), 0);
      @(negedge clk);
      check("empty_done_drop", int'(dn[id]), 0);
      return;
    end
    idx = 0; cyc = 0; stalls = 0; held = 0;
    while (idx < exp_q.size() && cyc < 20000) begin
      check("valid", int'(v[id]), 1);
      check("level", int'(lv[id]), exp_q[idx].l);
      check("row", int'(rw[id]), exp_q[idx].r);
      check("col", int'(cl[id]), exp_q[idx].c);
      if (full) check("last", int'(lst[id]), int'(idx == exp_q.size() - 1));
      if (cyc == abort_at) begin
        abort = 1'b1;
        ready = 1'($urandom_range(1));
        @(negedge clk);
        abort = 1'b0;
        ready = 1'b0;
        check("abort_valid", int'(v[id]), 0);
        check("abort_busy", int'(bsy[id]), 0);
        for (int j = 0; j < 3; j++) begin
          check("abort_no_done", int'(dn[id]), 0);
          @(negedge clk);
        end
        return;
      end
      if (hold && idx == 2 && held < 7) begin
        ready = 1'b0;
        held++;
      end else ready = ($urandom_range(99) < pct);
      start = ($urandom_range(3) == 0);
      if (!ready) stalls++;
      @(negedge clk);
      cyc++;
      if (ready) idx++;
    end
    ready = 1'b0;
    start = 1'b0;
    check("scan_in_budget", int'(cyc < 20000), 1);
`ifdef VJ_SCAN_PERF_EN
    check("perf_windows", int'(pw[id]), idx);
    check("perf_stall", int'(ps[id]), stalls);
`endif
    if (full) begin
      check("done_pulse", int'(dn[id]), 1);
      check("busy_drop", int'(bsy[id]), 0);
      check("valid_drop", int'(v[id]), 0);
      @(negedge clk);
      check("done_one_cycle", int'(dn[id]), 0);
    end
  endtask
  initial begin
    n_cmp = 0; n_bad = 0; sel = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0;
    init_geometry();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      sel = i;
      check("rst_valid", int'(v[i]), 0);
      check("rst_busy", int'(bsy[i]), 0);
      check("rst_done", int'(dn[i]), 0);
      check("rst_last", int'(lst[i]), 0);
      check("rst_coord", int'({lv[i], rw[i], cl[i]} != '0), 0);
    end
    reset = 1'b0;
    @(negedge clk);
    run(1, 1000, 1, 100, -1, 0);
    run(0, 350, 0, 100, -1, 0);
    run(2, 1000, 1, 100, -1, 0);
    run(2, 1000, 1, 0, 3, 0);
    run(2, 1000, 1, 100, -1, 0);
    run(3, 1000, 1, 100, -1, 0);
    run(4, 1000, 1, 100, -1, 1);
    run(1, 1000, 1, 50, -1, 0);
    for (int t = 0; t < 6; t++) begin
      run(4, 1000, 1, int'($urandom_range(30, 100)), -1, 0);
      run(4, 1000, 1, 70, int'($urandom_range(0, 20)), 0);
    end
    run(4, 1000, 1, 60, -1, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
